// File: rtl/noise_channel_gen.sv
// noise_channel_gen: LFSR noise voice (period timer, LFSR, envelope, length) feeding the APU mixer.
// Latency: out is combinational from registered LFSR/length/envelope state (zero cycles).
// Backpressure: none; state advances only on cpu_clk_en and frame-counter strobes.
module length_counter (
   input  logic       clk,
   input  logic       rst_l,
   input  logic       cpu_clk_en,
   input  logic       half_clk_en,
   input  logic       disable_l,
   input  logic       halt,
   input  logic       load,
   input  logic [4:0] load_data,
   output logic       non_zero
);
   logic [7:0] count;

   function automatic logic [7:0] length_lut(input logic [4:0] idx);
      logic [7:0] v;
      v = '0;
      case (idx)
         5'd0:  v = 8'd10;   5'd1:  v = 8'd254;  5'd2:  v = 8'd20;   5'd3:  v = 8'd2;
         5'd4:  v = 8'd40;   5'd5:  v = 8'd4;    5'd6:  v = 8'd80;   5'd7:  v = 8'd6;
         5'd8:  v = 8'd160;  5'd9:  v = 8'd8;    5'd10: v = 8'd60;   5'd11: v = 8'd10;
         5'd12: v = 8'd14;   5'd13: v = 8'd12;   5'd14: v = 8'd26;   5'd15: v = 8'd14;
         5'd16: v = 8'd12;   5'd17: v = 8'd16;   5'd18: v = 8'd24;   5'd19: v = 8'd18;
         5'd20: v = 8'd48;   5'd21: v = 8'd20;   5'd22: v = 8'd96;   5'd23: v = 8'd22;
         5'd24: v = 8'd192;  5'd25: v = 8'd24;   5'd26: v = 8'd72;   5'd27: v = 8'd26;
         5'd28: v = 8'd16;   5'd29: v = 8'd28;   5'd30: v = 8'd32;   5'd31: v = 8'd30;
      endcase
      return v;
   endfunction

   // Disable clears immediately, independent of the CPU strobe, and blocks any load.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         count <= '0;
      end else if (!disable_l) begin
         count <= '0;
      end else if (cpu_clk_en) begin
         if (load)
            count <= length_lut(load_data);
         else if (half_clk_en && !halt && count != '0)
            count <= count - 8'd1;
      end
   end

   assign non_zero = (count != '0);
endmodule

module noise_channel_gen #(
   parameter int LFSR_W    = 15,
   parameter int TAP_LONG  = 1,
   parameter int TAP_SHORT = 6,
   parameter int TIMER_W   = 12,
   parameter int VOL_W     = 4,
   parameter int PAL       = 0
) (
   input  logic              clk,
   input  logic              rst_l,
   input  logic              cpu_clk_en,
   input  logic              half_clk_en,
   input  logic              quarter_clk_en,
   input  logic              disable_l,
   input  logic [VOL_W-1:0]  vol,
   input  logic              const_vol,
   input  logic              length_halt,
   input  logic [3:0]        period_idx,
   input  logic              mode,
   input  logic [4:0]        length_load_data,
   input  logic              length_load,
   input  logic              env_load,
   input  logic              lfsr_reseed,
   output logic              length_non_zero,
   output logic [VOL_W-1:0]  out,
   output logic [LFSR_W-1:0] lfsr_state
);
   logic [TIMER_W-1:0] timer;
   logic [TIMER_W-1:0] reload;
   logic               pulse;
   logic [LFSR_W-1:0]  lfsr;
   logic [LFSR_W-1:0]  lfsr_shift;
   logic               fb;
   logic               env_start;
   logic [VOL_W-1:0]   env_div;
   logic [VOL_W-1:0]   env_decay;

   function automatic logic [TIMER_W-1:0] period_lut(input logic [3:0] idx);
      logic [11:0] p;
      p = '0;
      if (PAL != 0) begin
         case (idx)
            4'd0:  p = 12'd4;    4'd1:  p = 12'd8;    4'd2:  p = 12'd14;   4'd3:  p = 12'd30;
            4'd4:  p = 12'd60;   4'd5:  p = 12'd88;   4'd6:  p = 12'd118;  4'd7:  p = 12'd148;
            4'd8:  p = 12'd188;  4'd9:  p = 12'd236;  4'd10: p = 12'd354;  4'd11: p = 12'd472;
            4'd12: p = 12'd708;  4'd13: p = 12'd944;  4'd14: p = 12'd1890; 4'd15: p = 12'd3778;
         endcase
      end else begin
         case (idx)
            4'd0:  p = 12'd4;    4'd1:  p = 12'd8;    4'd2:  p = 12'd16;   4'd3:  p = 12'd32;
            4'd4:  p = 12'd64;   4'd5:  p = 12'd96;   4'd6:  p = 12'd128;  4'd7:  p = 12'd160;
            4'd8:  p = 12'd202;  4'd9:  p = 12'd254;  4'd10: p = 12'd380;  4'd11: p = 12'd508;
            4'd12: p = 12'd762;  4'd13: p = 12'd1016; 4'd14: p = 12'd2034; 4'd15: p = 12'd4068;
         endcase
      end
      return TIMER_W'(p);
   endfunction

   // Reloading with N-1 and pulsing at zero makes the shift period exactly N strobes.
   assign reload     = period_lut(period_idx) - TIMER_W'(1);
   assign pulse      = cpu_clk_en && (timer == '0);
   assign fb         = lfsr[0] ^ (mode ? lfsr[TAP_SHORT] : lfsr[TAP_LONG]);
   assign lfsr_shift = {fb, lfsr[LFSR_W-1:1]};

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         timer <= '0;
         lfsr  <= LFSR_W'(1);
      end else if (lfsr_reseed) begin
         timer <= reload;
         lfsr  <= LFSR_W'(1);
      end else if (cpu_clk_en) begin
         timer <= pulse ? reload : timer - TIMER_W'(1);
         if (pulse)
            lfsr <= (lfsr_shift == '0) ? LFSR_W'(1) : lfsr_shift;
      end
   end

   // env_load is applied after the quarter tick so a coincident tick still sees the old start flag.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         env_start <= 1'b0;
         env_div   <= '0;
         env_decay <= '0;
      end else if (cpu_clk_en) begin
         if (quarter_clk_en) begin
            if (env_start) begin
               env_start <= 1'b0;
               env_decay <= '1;
               env_div   <= vol;
            end else if (env_div == '0) begin
               env_div <= vol;
               if (env_decay != '0)
                  env_decay <= env_decay - VOL_W'(1);
               else if (length_halt)
                  env_decay <= '1;
            end else begin
               env_div <= env_div - VOL_W'(1);
            end
         end
         if (env_load)
            env_start <= 1'b1;
      end
   end

   length_counter u_length (
      .clk         (clk),
      .rst_l       (rst_l),
      .cpu_clk_en  (cpu_clk_en),
      .half_clk_en (half_clk_en),
      .disable_l   (disable_l),
      .halt        (length_halt),
      .load        (length_load),
      .load_data   (length_load_data),
      .non_zero    (length_non_zero)
   );

   assign out        = (!length_non_zero || lfsr[0]) ? '0 : (const_vol ? vol : env_decay);
   assign lfsr_state = lfsr;
endmodule
